// File: rtl/mvm_job_sequencer.sv
// Job controller for the 8x8 matrix-vector datapath: fetches a matrix and a vector
// from 64-bit memory, streams them into the datapath FIFOs and captures the results.
module mvm_job_sequencer #(
    parameter int ADDR_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  result_valid,
    output logic [23:0]           result [8],
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic                  mem_waitrequest,
    input  logic [63:0]           mem_readdata,
    input  logic                  mem_readdatavalid,
    output logic                  mvm_clr,
    output logic                  mvm_a_wren,
    output logic [7:0]            mvm_a_data [8],
    output logic                  mvm_b_wren,
    output logic [7:0]            mvm_b_data,
    input  logic                  mvm_done,
    input  logic [23:0]           mvm_out [8]
);
    typedef enum logic [3:0] {
        IDLE, CLEAR, FETCH, WAIT_DATA, WRITE_A, WRITE_B, WAIT_START, WAIT_DONE, SETTLE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [3:0]            word_cnt;
    logic [2:0]            col;
    logic [3:0]            settle_cnt;
    logic [63:0]           word_buf [9];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            base_q       <= '0;
            word_cnt     <= '0;
            col          <= '0;
            settle_cnt   <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            mem_address  <= '0;
            mem_read     <= 1'b0;
            mvm_clr      <= 1'b0;
            mvm_a_wren   <= 1'b0;
            mvm_b_wren   <= 1'b0;
            mvm_b_data   <= '0;
            for (int r = 0; r < 8; r++) begin
                result[r]     <= '0;
                mvm_a_data[r] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q       <= base_addr;
                        word_cnt     <= '0;
                        result_valid <= 1'b0;
                        busy         <= 1'b1;
                        mvm_clr      <= 1'b1;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    mvm_clr     <= 1'b0;
                    mem_read    <= 1'b1;
                    mem_address <= base_q;
                    state       <= FETCH;
                end
                FETCH: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (mem_readdatavalid) begin
                        word_buf[word_cnt] <= mem_readdata;
                        // Rows 0..7 are already buffered when the vector word lands,
                        // so column 0 can be presented on the same edge.
                        if (word_cnt == 4'd8) begin
                            col        <= '0;
                            mvm_a_wren <= 1'b1;
                            for (int r = 0; r < 8; r++) mvm_a_data[r] <= word_buf[r][7:0];
                            state      <= WRITE_A;
                        end else begin
                            word_cnt    <= word_cnt + 4'd1;
                            mem_read    <= 1'b1;
                            mem_address <= base_q + ADDR_WIDTH'(word_cnt + 4'd1);
                            state       <= FETCH;
                        end
                    end
                end
                WRITE_A: begin
                    if (col == 3'd7) begin
                        col        <= '0;
                        mvm_a_wren <= 1'b0;
                        mvm_b_wren <= 1'b1;
                        mvm_b_data <= word_buf[8][7:0];
                        state      <= WRITE_B;
                    end else begin
                        col <= col + 3'd1;
                        for (int r = 0; r < 8; r++)
                            mvm_a_data[r] <= word_buf[r][{col + 3'd1, 3'b000} +: 8];
                    end
                end
                WRITE_B: begin
                    if (col == 3'd7) begin
                        col        <= '0;
                        mvm_b_wren <= 1'b0;
                        state      <= WAIT_START;
                    end else begin
                        col        <= col + 3'd1;
                        mvm_b_data <= word_buf[8][{col + 3'd1, 3'b000} +: 8];
                    end
                end
                // A done level still high from the previous job must drop first.
                WAIT_START: begin
                    if (!mvm_done) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mvm_done) begin
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        for (int r = 0; r < 8; r++) result[r] <= mvm_out[r];
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_job_sequencer.sv
// Bench for mvm_job_sequencer: random-latency memory model, a behavioural datapath
// that multiplies whatever the DUT writes, and results predicted from memory contents.
module tb_mvm_job_sequencer;
    localparam int AW      = 32;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 3000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, result_valid;
    logic [23:0]   result [8];
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_waitrequest = 1'b0;
    logic [63:0]   mem_readdata = '0;
    logic          mem_readdatavalid = 1'b0;
    logic          mvm_clr, mvm_a_wren, mvm_b_wren;
    logic [7:0]    mvm_a_data [8];
    logic [7:0]    mvm_b_data;
    logic          mvm_done = 1'b0;
    logic [23:0]   mvm_out [8] = '{default: 24'h0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cycle = 0;

    mvm_job_sequencer #(.ADDR_WIDTH(AW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .result_valid(result_valid), .result(result),
        .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .mvm_clr(mvm_clr), .mvm_a_wren(mvm_a_wren), .mvm_a_data(mvm_a_data),
        .mvm_b_wren(mvm_b_wren), .mvm_b_data(mvm_b_data),
        .mvm_done(mvm_done), .mvm_out(mvm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory: per-request random stall, random read latency, one outstanding read.
    logic [63:0]   mem [1024];
    int            stall_max = 0, lat_min = 1, lat_max = 1;
    bit            in_req = 0, pend = 0, prev_stalled = 0;
    int            wait_left = 0, pend_cnt = 0, last_beat = 0, stab_viol = 0;
    logic [63:0]   pend_data = '0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] addr_log [$];

    always @(negedge clk) begin
        mem_readdatavalid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = pend_data;
                pend              = 0;
                last_beat         = cyc + 1;
            end else begin
                pend_cnt--;
            end
        end
        if (prev_stalled && (!mem_read || mem_address !== prev_addr)) stab_viol++;
        mem_waitrequest = 1'b0;
        prev_stalled    = 0;
        if (mem_read) begin
            if (!in_req) begin
                in_req    = 1;
                wait_left = $urandom_range(0, stall_max);
            end
            if (wait_left > 0) begin
                mem_waitrequest = 1'b1;
                wait_left--;
                prev_stalled = 1;
                prev_addr    = mem_address;
            end else begin
                in_req = 0;
                addr_log.push_back(mem_address);
                pend      = 1;
                pend_cnt  = $urandom_range(lat_min, lat_max) - 1;
                pend_data = mem[mem_address[9:0]];
            end
        end
    end

    // Datapath: logs FIFO writes, then drops any stale done and raises it with the product.
    logic [63:0] a_log [$];
    logic [7:0]  b_log [$];
    logic [63:0] col_word;
    int clr_count = 0, clr_cycle = -1, first_read_cycle = -1, overlap = 0;
    int a_first = -1, a_last = -1, b_first = -1, b_last = -1, rv_cycle = -1, done_edge = -1;
    bit rv_prev = 0, dp_active = 0;
    int dp_timer = 0, dp_sum = 0, stale_hold = 1, compute_delay = 4;

    always @(negedge clk) begin
        if (mvm_clr) begin
            clr_count++;
            clr_cycle        = cyc;
            first_read_cycle = -1;
            a_log.delete();
            b_log.delete();
        end
        if (mem_read && first_read_cycle < 0) first_read_cycle = cyc;
        if (mvm_a_wren && mvm_b_wren) overlap++;
        if (mvm_a_wren) begin
            for (int r = 0; r < 8; r++) col_word[8*r +: 8] = mvm_a_data[r];
            if (a_log.size() == 0) a_first = cyc;
            a_last = cyc;
            a_log.push_back(col_word);
        end
        if (mvm_b_wren) begin
            if (b_log.size() == 0) b_first = cyc;
            b_last = cyc;
            b_log.push_back(mvm_b_data);
        end
        if (result_valid && !rv_prev) rv_cycle = cyc;
        rv_prev = result_valid;
        if (dp_active) begin
            dp_timer++;
            if (dp_timer == stale_hold) mvm_done = 1'b0;
            if (dp_timer == stale_hold + compute_delay) begin
                for (int r = 0; r < 8; r++) begin
                    dp_sum = 0;
                    for (int c = 0; c < 8; c++)
                        if (c < a_log.size() && c < b_log.size())
                            dp_sum += int'(a_log[c][8*r +: 8]) * int'(b_log[c]);
                    mvm_out[r] = 24'(dp_sum);
                end
                mvm_done  = 1'b1;
                done_edge = cyc + 1;
                dp_active = 0;
            end
        end else if (mvm_b_wren && b_log.size() == 8) begin
            dp_active = 1;
            dp_timer  = 0;
        end
    end

    logic [7:0]  cur_a [8][8];
    logic [7:0]  cur_b [8];
    logic [23:0] exp_res [8];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_job(input logic [AW-1:0] base);
        logic [63:0] w;
        int s;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) w[8*c +: 8] = cur_a[r][c];
            mem[10'(base) + 10'(r)] = w;
        end
        for (int c = 0; c < 8; c++) w[8*c +: 8] = cur_b[c];
        mem[10'(base) + 10'd8] = w;
        for (int r = 0; r < 8; r++) begin
            s = 0;
            for (int c = 0; c < 8; c++) s += int'(cur_a[r][c]) * int'(cur_b[c]);
            exp_res[r] = 24'(s);
        end
    endtask

    task automatic random_job();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) cur_a[r][c] = 8'($urandom);
        for (int c = 0; c < 8; c++) cur_b[c] = 8'($urandom);
    endtask

    task automatic start_job(input logic [AW-1:0] base);
        tick();
        addr_log.delete();
        base_addr   = base;
        start       = 1'b1;
        start_cycle = cyc;
        tick();
        start     = 1'b0;
        base_addr = $urandom;
    endtask

    task automatic wait_job(output bit ok);
        int n;
        n = 0;
        while (!(result_valid && !busy) && n < TIMEOUT) begin
            tick();
            n++;
        end
        ok = (n < TIMEOUT);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, result_valid, mem_read, mvm_clr, mvm_a_wren, mvm_b_wren} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {busy, result_valid, mem_read, mvm_clr, mvm_a_wren, mvm_b_wren});
        end
        checks++;
        if (mem_address !== '0 || mvm_b_data !== 8'h0) begin
            errors++;
            $display("[TB] FAIL reset_addr_bdata: got %0h/%0h expected 0/0", mem_address, mvm_b_data);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (result[r] !== 24'h0 || mvm_a_data[r] !== 8'h0) begin
                errors++;
                $display("[TB] FAIL reset_row%0d: got %0h/%0h expected 0/0", r, result[r], mvm_a_data[r]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        bit ok;
        int clr0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) cur_a[r][c] = (r == c) ? 8'd1 : 8'd0;
        for (int c = 0; c < 8; c++) cur_b[c] = 8'(c + 1);
        stall_max = 0; lat_min = 1; lat_max = 1; stale_hold = 1; compute_delay = 4;
        load_job(32'h100);
        clr0 = clr_count;
        start_job(32'h100);
        wait_job(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL identity_timeout: got busy=%0b expected completion", busy); end
        checks++;
        if (clr_cycle != start_cycle + 1 || clr_count - clr0 != 1) begin
            errors++;
            $display("[TB] FAIL identity_clr: got cycle %0d count %0d expected %0d/1", clr_cycle, clr_count - clr0, start_cycle + 1);
        end
        checks++;
        if (first_read_cycle != start_cycle + 2) begin
            errors++;
            $display("[TB] FAIL identity_first_read: got %0d expected %0d", first_read_cycle, start_cycle + 2);
        end
        checks++;
        if (last_beat != start_cycle + 20) begin
            errors++;
            $display("[TB] FAIL identity_fetch_time: got %0d expected %0d", last_beat, start_cycle + 20);
        end
        checks++;
        if (a_first != last_beat) begin
            errors++;
            $display("[TB] FAIL identity_first_a: got %0d expected %0d", a_first, last_beat);
        end
        checks++;
        if (a_log.size() != 8 || b_log.size() != 8 || a_last - a_first != 7 ||
            b_first != a_last + 1 || b_last - b_first != 7) begin
            errors++;
            $display("[TB] FAIL identity_wren_runs: got a %0d..%0d (%0d) b %0d..%0d (%0d) expected 8+8 contiguous",
                     a_first, a_last, a_log.size(), b_first, b_last, b_log.size());
        end
        checks++;
        if (overlap != 0) begin errors++; $display("[TB] FAIL wren_overlap: got %0d expected 0", overlap); end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (result[r] !== 24'(r + 1)) begin
                errors++;
                $display("[TB] FAIL identity_result%0d: got %0h expected %0h", r, result[r], r + 1);
            end
        end
        checks++;
        if (rv_cycle != done_edge + SETTLE) begin
            errors++;
            $display("[TB] FAIL identity_settle: got %0d expected %0d", rv_cycle, done_edge + SETTLE);
        end
    endtask

    task automatic test_full_scale();
        bit ok;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) cur_a[r][c] = 8'hFF;
        for (int c = 0; c < 8; c++) cur_b[c] = 8'hFF;
        stall_max = 0; lat_min = 1; lat_max = 2; stale_hold = 2; compute_delay = 3;
        load_job(32'h040);
        start_job(32'h040);
        wait_job(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL full_timeout: got busy=%0b expected completion", busy); end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (result[r] !== 24'h07F008) begin
                errors++;
                $display("[TB] FAIL full_result%0d: got %0h expected 7f008", r, result[r]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int stab0;
        logic [AW-1:0] base;
        logic [63:0] exp_col, got_col;
        logic [7:0] got_b;
        stall_max = 5; lat_min = 1; lat_max = 4; stale_hold = 1; compute_delay = 2;
        for (int job = 0; job < 3; job++) begin
            random_job();
            base = AW'($urandom_range(0, 900));
            load_job(base);
            stab0 = stab_viol;
            start_job(base);
            wait_job(ok);
            checks++;
            if (!ok || addr_log.size() != 9) begin
                errors++;
                $display("[TB] FAIL stall_reads: got ok=%0b reads=%0d expected 1/9", ok, addr_log.size());
            end
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (k >= addr_log.size() || addr_log[k] !== base + 32'(k)) begin
                    errors++;
                    $display("[TB] FAIL stall_addr%0d: got %0h expected %0h", k,
                             (k < addr_log.size()) ? addr_log[k] : 32'hFFFFFFFF, base + 32'(k));
                end
            end
            checks++;
            if (stab_viol != stab0) begin
                errors++;
                $display("[TB] FAIL stall_stable: got %0d violations expected 0", stab_viol - stab0);
            end
            for (int c = 0; c < 8; c++) begin
                for (int r = 0; r < 8; r++) exp_col[8*r +: 8] = cur_a[r][c];
                got_col = (c < a_log.size()) ? a_log[c] : 64'hx;
                got_b   = (c < b_log.size()) ? b_log[c] : 8'hx;
                checks++;
                if (got_col !== exp_col || got_b !== cur_b[c]) begin
                    errors++;
                    $display("[TB] FAIL stall_col%0d: got %0h/%0h expected %0h/%0h", c, got_col, got_b, exp_col, cur_b[c]);
                end
            end
            for (int r = 0; r < 8; r++) begin
                checks++;
                if (result[r] !== exp_res[r]) begin
                    errors++;
                    $display("[TB] FAIL stall_result%0d: got %0h expected %0h", r, result[r], exp_res[r]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int clr0;
        clr0 = clr_count;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) cur_a[r][c] = (r == c) ? 8'd1 : 8'd0;
        for (int c = 0; c < 8; c++) cur_b[c] = 8'(c + 1);
        stall_max = 0; lat_min = 1; lat_max = 1; stale_hold = 1; compute_delay = 3;
        load_job(32'h100);
        start_job(32'h100);
        wait_job(ok1);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) cur_a[r][c] = 8'd2;
        for (int c = 0; c < 8; c++) cur_b[c] = 8'd1;
        stale_hold = 6;
        load_job(32'h180);
        start_job(32'h180);
        wait_job(ok2);
        checks++;
        if (!ok1 || !ok2 || clr_count - clr0 != 2) begin
            errors++;
            $display("[TB] FAIL b2b_jobs: got ok=%0b%0b clr=%0d expected 11/2", ok1, ok2, clr_count - clr0);
        end
        checks++;
        if (rv_cycle != done_edge + SETTLE) begin
            errors++;
            $display("[TB] FAIL b2b_stale_done: got %0d expected %0d", rv_cycle, done_edge + SETTLE);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (result[r] !== 24'd16) begin
                errors++;
                $display("[TB] FAIL b2b_result%0d: got %0h expected 10", r, result[r]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int clr0, n1, n2;
        logic [AW-1:0] base;
        random_job();
        base = 32'h200;
        stall_max = 0; lat_min = 1; lat_max = 2; stale_hold = 2; compute_delay = 8;
        load_job(base);
        clr0 = clr_count;
        start_job(base);
        n1 = 0;
        while (!mem_read && n1 < TIMEOUT) begin tick(); n1++; end
        base_addr = 32'h300; start = 1'b1; tick(); start = 1'b0;
        n2 = 0;
        while (b_log.size() < 8 && n2 < TIMEOUT) begin tick(); n2++; end
        repeat (stale_hold + 2) tick();
        base_addr = 32'h300; start = 1'b1; tick(); start = 1'b0;
        wait_job(ok);
        repeat (10) tick();
        checks++;
        if (!ok || n1 >= TIMEOUT || n2 >= TIMEOUT) begin
            errors++;
            $display("[TB] FAIL busy_timeout: got ok=%0b waits=%0d/%0d expected completion", ok, n1, n2);
        end
        checks++;
        if (clr_count - clr0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_single_job: got clr=%0d busy=%0b expected 1/0", clr_count - clr0, busy);
        end
        checks++;
        if (addr_log.size() != 9 || addr_log[0] !== base || addr_log[8] !== base + 32'd8) begin
            errors++;
            $display("[TB] FAIL busy_addrs: got %0d reads first %0h expected 9 from %0h", addr_log.size(),
                     (addr_log.size() > 0) ? addr_log[0] : 32'hFFFFFFFF, base);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (result[r] !== exp_res[r]) begin
                errors++;
                $display("[TB] FAIL busy_result%0d: got %0h expected %0h", r, result[r], exp_res[r]);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        int n;
        random_job();
        stall_max = 0; lat_min = 6; lat_max = 6; stale_hold = 1; compute_delay = 2;
        load_job(32'h280);
        start_job(32'h280);
        n = 0;
        while (addr_log.size() < 1 && n < TIMEOUT) begin tick(); n++; end
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        checks++;
        if ({busy, result_valid, mem_read, mvm_clr, mvm_a_wren, mvm_b_wren} !== 6'b0 || mem_address !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got %b addr %0h expected 000000 addr 0",
                     {busy, result_valid, mem_read, mvm_clr, mvm_a_wren, mvm_b_wren}, mem_address);
        end
        checks++;
        if (addr_log.size() != 1 || n >= TIMEOUT) begin
            errors++;
            $display("[TB] FAIL midreset_idle: got %0d reads expected 1", addr_log.size());
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (result[r] !== 24'h0 || mvm_a_data[r] !== 8'h0) begin
                errors++;
                $display("[TB] FAIL midreset_row%0d: got %0h/%0h expected 0/0", r, result[r], mvm_a_data[r]);
            end
        end
        random_job();
        lat_min = 1; lat_max = 3;
        load_job(32'h2C0);
        start_job(32'h2C0);
        wait_job(ok);
        checks++;
        if (!ok || addr_log.size() != 9) begin
            errors++;
            $display("[TB] FAIL midreset_rerun: got ok=%0b reads=%0d expected 1/9", ok, addr_log.size());
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (result[r] !== exp_res[r]) begin
                errors++;
                $display("[TB] FAIL midreset_result%0d: got %0h expected %0h", r, result[r], exp_res[r]);
            end
        end
    endtask

    initial begin
        $display("[TB] mvm_job_sequencer bench starting");
        test_reset();
        test_identity();
        test_full_scale();
        test_stall();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
